mx_block_serialiser: RTL and testbench
======================================

Name: mx_block_serialiser

Overview:
- Downstream neighbour of the bf16-to-MX integer converter.
- Takes one complete MX block per cycle: k signed elements plus one shared 8-bit exponent, tagged by a valid strobe that the wrapper delays to match converter latency.
- Emits the block as a ready/valid stream of k/lanes beats to the memory/NoC writer.
- Buffers up to two blocks, because the converter has no stall and cannot be backpressured.

Parameters:
- bit_width, 8, element width in bits. Must match the converter.
- k, 32, elements per MX block. Must be a multiple of lanes.
- lanes, 8, elements per output beat. Range 1..k.

Ports:
- i_clk, input, 1, clock.
- i_rst, input, 1, synchronous active-high reset.
- i_valid, input, 1, a block is present on i_mx_vec/i_mx_exp this cycle.
- i_mx_vec, input, bit_width x [k], block elements. Index 0 is the first element.
- i_mx_exp, input, 8, shared block exponent.
- o_valid, output, 1, output beat valid.
- i_ready, input, 1, consumer accepts the beat.
- o_elems, output, bit_width x [lanes], beat elements. o_elems[j] = element beat*lanes+j.
- o_exp, output, 8, exponent of the block being sent. Constant for all beats of a block.
- o_first, output, 1, first beat of a block.
- o_last, output, 1, last beat of a block.
- o_ovf, output, 1, sticky: a block was dropped.

Behaviour:
- Reset (synchronous, i_rst high at a clock edge):
  - o_valid=0, o_first=0, o_last=0, o_ovf=0, o_elems=0, o_exp=0.
  - Occupancy=0, beat counter=0.
  - Reset wins over a simultaneous i_valid. A block in flight is discarded without its o_last.
- Storage:
  - ACTIVE register (block being sent) and PENDING register (next block).
  - Occupancy is 0, 1 or 2.
  - BEATS = k/lanes. The beat counter is $clog2(BEATS) bits, minimum 1.
- States:
  - IDLE (occ=0): o_valid=0.
  - SEND (occ>=1): o_valid=1, o_elems = ACTIVE slice[beat], o_first=(beat==0), o_last=(beat==BEATS-1).
  - Outputs are driven from registers only. No combinational path from i_valid or i_ready to any output.
- Handshake:
  - A beat transfers when o_valid && i_ready. Only then does beat increment.
  - While o_valid is high and i_ready is low, o_elems, o_exp, o_first and o_last hold stable.
  - Last-beat transfer: beat->0. If PENDING is full, PENDING moves to ACTIVE and the next block's first beat is presented the next cycle with no bubble. Otherwise go to IDLE.
- Input acceptance, evaluated per cycle with ld = last-beat transfer this cycle:
  - occ=0: load ACTIVE. o_valid rises next cycle (1-cycle latency, first beat visible at cycle n+1).
  - occ=1, !ld: load PENDING.
  - occ=1, ld: load ACTIVE directly (back-to-back, no bubble).
  - occ=2, ld: PENDING->ACTIVE and the input loads PENDING, in the same cycle.
  - occ=2, !ld: input dropped, o_ovf set. o_ovf stays set until reset. Stored blocks are unaffected.
- BEATS=1 (lanes=k): every beat asserts both o_first and o_last.
- Data is passed through unmodified. No arithmetic on elements or exponent.

Optional Feature:
- Macro: MX_SER_STATS_EN.
- Defined:
  - Adds output o_blk_cnt[15:0]: count of blocks fully sent (last-beat transfers).
  - Adds output o_drop_cnt[7:0]: count of dropped blocks.
  - Both saturate at all-ones, reset to 0, and are registered.
- Undefined: neither port exists and no counter logic is built. All other behaviour is identical.

Test Plan (k=32, lanes=8, bit_width=8):
- Single block, i_ready tied 1:
  - Stimulus: elements 0..31 = 0x00..0x1F, exp=0x85, i_valid at cycle 0.
  - Required: beats at cycles 1-4; o_elems[0] = 0x00, 0x08, 0x10, 0x18; o_first only at cycle 1; o_last only at cycle 4; o_exp=0x85 throughout; o_valid=0 at cycle 5.
- Backpressure:
  - Stimulus: same block, i_ready=0 for cycles 1-3, then 1.
  - Required: beat 0 held stable through cycles 1-3; transfer at cycle 4; o_last at cycle 7.
- Back-to-back:
  - Stimulus: i_valid at cycles 0 and 4 (exps 0x10, 0x20), i_ready=1.
  - Required: 8 consecutive beats in cycles 1-8; o_exp switches 0x10->0x20 at cycle 5; o_ovf=0.
- Overflow:
  - Stimulus: i_ready=0, i_valid at cycles 0, 1, 2 (exps 0x01, 0x02, 0x03).
  - Required: o_ovf=1 from cycle 3; after releasing i_ready, blocks 0x01 then 0x02 sent; 0x03 never appears.
- Simultaneous full+last:
  - Stimulus: occ=2, i_valid coincides with a last-beat transfer.
  - Required: no drop; o_ovf=0; three blocks emitted in order.
- Reset mid-block:
  - Stimulus: i_rst at beat 2 of a block.
  - Required: next cycle o_valid=0 and o_ovf=0; a new block then starts with o_first=1 and beat 0.

Source files
------------

// File: rtl/mx_block_serialiser.sv
// Two-deep MX block buffer that streams each block out as k/lanes ready/valid beats.
// Define MX_SER_STATS_EN to add the o_blk_cnt / o_drop_cnt statistics counters.
module mx_block_serialiser #(
  parameter int bit_width = 8,
  parameter int k         = 32,
  parameter int lanes     = 8
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic                             i_valid,
  input  logic [k-1:0][bit_width-1:0]      i_mx_vec,
  input  logic [7:0]                       i_mx_exp,
  output logic                             o_valid,
  input  logic                             i_ready,
  output logic [lanes-1:0][bit_width-1:0]  o_elems,
  output logic [7:0]                       o_exp,
  output logic                             o_first,
  output logic                             o_last,
  output logic                             o_ovf
`ifdef MX_SER_STATS_EN
  ,
  output logic [15:0]                      o_blk_cnt,
  output logic [7:0]                       o_drop_cnt
`endif
);

  localparam int BEATS = k / lanes;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int VW    = k * bit_width;
  localparam int SW    = lanes * bit_width;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  typedef enum logic [1:0] {OCC_EMPTY, OCC_ONE, OCC_FULL} occ_t;

  occ_t            occ, occ_n;
  logic [BW-1:0]   beat, beat_n;
  logic [VW-1:0]   act_vec, act_vec_n, pend_vec, pend_vec_n, in_vec;
  logic [7:0]      act_exp, act_exp_n, pend_exp, pend_exp_n;
  logic [SW-1:0]   slice_n;
  logic            xfer, ld, drop, busy_n;

  assign in_vec = i_mx_vec;

  // The converter cannot stall, so every cycle either stores the input or drops it.
  always_comb begin
    occ_n      = occ;
    beat_n     = beat;
    act_vec_n  = act_vec;
    act_exp_n  = act_exp;
    pend_vec_n = pend_vec;
    pend_exp_n = pend_exp;
    drop       = 1'b0;
    xfer       = o_valid && i_ready;
    ld         = xfer && (beat == LAST_BEAT);

    if (xfer) beat_n = ld ? '0 : beat + BW'(1);

    case (occ)
      OCC_EMPTY: begin
        if (i_valid) begin
          act_vec_n = in_vec;
          act_exp_n = i_mx_exp;
          occ_n     = OCC_ONE;
        end
      end
      OCC_ONE: begin
        if (ld) begin
          if (i_valid) begin
            act_vec_n = in_vec;
            act_exp_n = i_mx_exp;
          end else begin
            occ_n = OCC_EMPTY;
          end
        end else if (i_valid) begin
          pend_vec_n = in_vec;
          pend_exp_n = i_mx_exp;
          occ_n      = OCC_FULL;
        end
      end
      default: begin
        if (ld) begin
          act_vec_n = pend_vec;
          act_exp_n = pend_exp;
          if (i_valid) begin
            pend_vec_n = in_vec;
            pend_exp_n = i_mx_exp;
          end else begin
            occ_n = OCC_ONE;
          end
        end else if (i_valid) begin
          drop = 1'b1;
        end
      end
    endcase

    busy_n  = (occ_n != OCC_EMPTY);
    slice_n = act_vec_n[int'(beat_n) * SW +: SW];
  end

  // Outputs are registered copies of the next state so nothing leaks from i_valid/i_ready.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      occ      <= OCC_EMPTY;
      beat     <= '0;
      act_vec  <= '0;
      act_exp  <= '0;
      pend_vec <= '0;
      pend_exp <= '0;
      o_valid  <= 1'b0;
      o_elems  <= '0;
      o_exp    <= '0;
      o_first  <= 1'b0;
      o_last   <= 1'b0;
      o_ovf    <= 1'b0;
    end else begin
      occ      <= occ_n;
      beat     <= beat_n;
      act_vec  <= act_vec_n;
      act_exp  <= act_exp_n;
      pend_vec <= pend_vec_n;
      pend_exp <= pend_exp_n;
      o_valid  <= busy_n;
      o_elems  <= busy_n ? slice_n : '0;
      o_exp    <= busy_n ? act_exp_n : 8'h00;
      o_first  <= busy_n && (beat_n == '0);
      o_last   <= busy_n && (beat_n == LAST_BEAT);
      if (drop) o_ovf <= 1'b1;
    end
  end

`ifdef MX_SER_STATS_EN
  // Saturating counters of completed and dropped blocks.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_blk_cnt  <= '0;
      o_drop_cnt <= '0;
    end else begin
      if (ld && (o_blk_cnt != 16'hFFFF)) o_blk_cnt <= o_blk_cnt + 16'd1;
      if (drop && (o_drop_cnt != 8'hFF)) o_drop_cnt <= o_drop_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mx_block_serialiser.sv
// Bench for mx_block_serialiser: directed scenarios plus random traffic,
// all compared against a queue-based model of the block stream.
module tb_mx_block_serialiser;

  localparam int BWID  = 8;
  localparam int K     = 32;
  localparam int LANES = 8;
  localparam int BEATS = K / LANES;
  localparam int VW    = K * BWID;
  localparam int SW    = LANES * BWID;
  localparam int BUSW  = 3 + 8 + SW + 1;

  logic                        i_clk, i_rst, i_valid, i_ready;
  logic [K-1:0][BWID-1:0]      i_mx_vec;
  logic [7:0]                  i_mx_exp;
  logic                        o_valid, o_first, o_last, o_ovf;
  logic [LANES-1:0][BWID-1:0]  o_elems;
  logic [7:0]                  o_exp;
`ifdef MX_SER_STATS_EN
  logic [15:0]                 o_blk_cnt;
  logic [7:0]                  o_drop_cnt;
`endif

  int checks = 0;
  int fails  = 0;

  mx_block_serialiser #(.bit_width(BWID), .k(K), .lanes(LANES)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .i_mx_vec(i_mx_vec),
    .i_mx_exp(i_mx_exp), .o_valid(o_valid), .i_ready(i_ready), .o_elems(o_elems),
    .o_exp(o_exp), .o_first(o_first), .o_last(o_last), .o_ovf(o_ovf)
`ifdef MX_SER_STATS_EN
    , .o_blk_cnt(o_blk_cnt), .o_drop_cnt(o_drop_cnt)
`endif
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Reference model: a FIFO of stored blocks, the front one being streamed.
  typedef struct {
    logic [VW-1:0] vec;
    logic [7:0]    exp;
  } blk_t;

  blk_t q[$];
  int   m_beat;
  bit   m_ovf;
  int   m_blk_cnt, m_drop_cnt;
  logic [VW-1:0] ramp;

  task automatic model_step(input logic rst, input logic v, input logic [VW-1:0] vec,
                            input logic [7:0] e, input logic rdy);
    int  occ;
    bit  ld;
    blk_t b;
    if (rst) begin
      q.delete();
      m_beat = 0; m_ovf = 0; m_blk_cnt = 0; m_drop_cnt = 0;
      return;
    end
    occ = q.size();
    ld  = 0;
    if (occ > 0 && rdy) begin
      if (m_beat == BEATS - 1) begin
        ld = 1;
        void'(q.pop_front());
        m_beat = 0;
        m_blk_cnt++;
      end else begin
        m_beat++;
      end
    end
    if (v) begin
      if (occ == 2 && !ld) begin
        m_ovf = 1;
        m_drop_cnt++;
      end else begin
        b.vec = vec;
        b.exp = e;
        q.push_back(b);
      end
    end
  endtask

  function automatic logic [BUSW-1:0] model_bus();
    blk_t b;
    if (q.size() == 0) return {1'b0, (BUSW-2)'(0), m_ovf};
    b = q[0];
    return {1'b1, m_beat == 0, m_beat == BEATS - 1, b.exp, b.vec[m_beat*SW +: SW], m_ovf};
  endfunction

  function automatic logic [BUSW-1:0] dut_bus();
    if (o_valid === 1'b1) return {1'b1, o_first, o_last, o_exp, o_elems, o_ovf};
    return {o_valid, (BUSW-2)'(0), o_ovf};
  endfunction

  task automatic tick(input logic rst, input logic v, input logic [VW-1:0] vec,
                      input logic [7:0] e, input logic rdy);
    i_rst = rst; i_valid = v; i_mx_vec = vec; i_mx_exp = e; i_ready = rdy;
    @(posedge i_clk);
    model_step(rst, v, vec, e, rdy);
    #1;
  endtask

  function automatic logic [VW-1:0] rand_vec();
    logic [VW-1:0] r;
    for (int i = 0; i < VW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic test_reset();
    tick(1, 1, rand_vec(), 8'hAA, 1);
    checks++;
    if ({o_valid, o_first, o_last, o_ovf, o_exp, o_elems} !== '0) begin
      fails++;
      $display("[TB] FAIL reset: got v%b f%b l%b ovf%b exp %h elems %h, required all zero",
               o_valid, o_first, o_last, o_ovf, o_exp, o_elems);
    end
  endtask

  task automatic test_single();
    tick(1, 0, '0, 8'h00, 1);
    tick(0, 1, ramp, 8'h85, 1);
    for (int c = 1; c <= 5; c++) begin
      checks++;
      if (dut_bus() !== model_bus()) begin
        fails++;
        $display("[TB] FAIL single c%0d: got %h required %h", c, dut_bus(), model_bus());
      end
      if (c <= 4) begin
        checks++;
        if (o_elems[0] !== 8'(8 * (c - 1)) || o_exp !== 8'h85 || o_first !== (c == 1) || o_last !== (c == 4)) begin
          fails++;
          $display("[TB] FAIL single_beat c%0d: got e0 %h exp %h f%b l%b", c, o_elems[0], o_exp, o_first, o_last);
        end
      end else begin
        checks++;
        if (o_valid !== 1'b0) begin
          fails++;
          $display("[TB] FAIL single_idle: got o_valid %b required 0", o_valid);
        end
      end
      tick(0, 0, '0, 8'h00, 1);
    end
  endtask

  task automatic test_backpressure();
    tick(1, 0, '0, 8'h00, 1);
    tick(0, 1, ramp, 8'h85, 0);
    for (int c = 1; c <= 8; c++) begin
      checks++;
      if (dut_bus() !== model_bus()) begin
        fails++;
        $display("[TB] FAIL backpressure c%0d: got %h required %h", c, dut_bus(), model_bus());
      end
      if (c <= 4 || c == 7) begin
        checks++;
        if (o_valid !== 1'b1 || o_first !== (c <= 4) || o_last !== (c == 7)) begin
          fails++;
          $display("[TB] FAIL backpressure_beat c%0d: got v%b f%b l%b", c, o_valid, o_first, o_last);
        end
      end
      tick(0, 0, '0, 8'h00, c >= 4);
    end
  endtask

  task automatic test_back_to_back();
    tick(1, 0, '0, 8'h00, 1);
    tick(0, 1, rand_vec(), 8'h10, 1);
    for (int c = 1; c <= 9; c++) begin
      checks++;
      if (dut_bus() !== model_bus()) begin
        fails++;
        $display("[TB] FAIL back_to_back c%0d: got %h required %h", c, dut_bus(), model_bus());
      end
      if (c <= 8) begin
        checks++;
        if (o_valid !== 1'b1 || o_ovf !== 1'b0 || o_exp !== ((c >= 5) ? 8'h20 : 8'h10)) begin
          fails++;
          $display("[TB] FAIL back_to_back_exp c%0d: got v%b ovf%b exp %h", c, o_valid, o_ovf, o_exp);
        end
      end
      tick(0, c == 4, rand_vec(), 8'h20, 1);
    end
  endtask

  task automatic test_overflow();
    tick(1, 0, '0, 8'h00, 0);
    tick(0, 1, rand_vec(), 8'h01, 0);
    tick(0, 1, rand_vec(), 8'h02, 0);
    tick(0, 1, rand_vec(), 8'h03, 0);
    checks++;
    if (o_ovf !== 1'b1) begin
      fails++;
      $display("[TB] FAIL overflow_flag: got o_ovf %b required 1", o_ovf);
    end
    for (int c = 3; c <= 14; c++) begin
      checks++;
      if (dut_bus() !== model_bus() || (o_valid === 1'b1 && o_exp === 8'h03)) begin
        fails++;
        $display("[TB] FAIL overflow c%0d: got %h required %h", c, dut_bus(), model_bus());
      end
      tick(0, 0, '0, 8'h00, c >= 5);
    end
  endtask

  task automatic test_full_last();
    logic [7:0] seen[$];
    tick(1, 0, '0, 8'h00, 1);
    for (int c = 0; c <= 16; c++) begin
      tick(0, (c == 0 || c == 1 || c == 4), rand_vec(), 8'(8'hA0 + c), 1);
      checks++;
      if (dut_bus() !== model_bus() || o_ovf !== 1'b0) begin
        fails++;
        $display("[TB] FAIL full_last c%0d: got %h required %h", c + 1, dut_bus(), model_bus());
      end
      if (o_valid === 1'b1 && o_first === 1'b1) seen.push_back(o_exp);
    end
    checks++;
    if (seen.size() != 3 || seen[0] !== 8'hA0 || seen[1] !== 8'hA1 || seen[2] !== 8'hA4) begin
      fails++;
      $display("[TB] FAIL full_last_order: got %0d blocks, required A0 A1 A4", seen.size());
    end
  endtask

  task automatic test_reset_mid();
    tick(1, 0, '0, 8'h00, 1);
    tick(0, 1, ramp, 8'h55, 1);
    tick(0, 0, '0, 8'h00, 1);
    tick(0, 0, '0, 8'h00, 1);
    tick(1, 1, rand_vec(), 8'h66, 1);
    checks++;
    if (o_valid !== 1'b0 || o_ovf !== 1'b0) begin
      fails++;
      $display("[TB] FAIL reset_mid: got v%b ovf%b required 0 0", o_valid, o_ovf);
    end
    tick(0, 1, ramp, 8'h77, 0);
    checks++;
    if (o_valid !== 1'b1 || o_first !== 1'b1 || o_elems[0] !== 8'h00 || o_exp !== 8'h77) begin
      fails++;
      $display("[TB] FAIL reset_mid_restart: got v%b f%b e0 %h exp %h", o_valid, o_first, o_elems[0], o_exp);
    end
  endtask

  task automatic test_random();
    tick(1, 0, '0, 8'h00, 1);
    for (int c = 0; c < 600; c++) begin
      tick($urandom_range(0, 149) == 0, $urandom_range(0, 9) < 4, rand_vec(),
           8'($urandom), $urandom_range(0, 9) < 7);
      checks++;
      if (dut_bus() !== model_bus()) begin
        fails++;
        $display("[TB] FAIL random c%0d: got %h required %h", c, dut_bus(), model_bus());
      end
    end
`ifdef MX_SER_STATS_EN
    checks++;
    if (o_blk_cnt !== 16'(m_blk_cnt) || o_drop_cnt !== 8'(m_drop_cnt)) begin
      fails++;
      $display("[TB] FAIL stats: got blk %0d drop %0d required %0d %0d",
               o_blk_cnt, o_drop_cnt, m_blk_cnt, m_drop_cnt);
    end
`endif
  endtask

  initial begin
    for (int i = 0; i < K; i++) ramp[i*BWID +: BWID] = 8'(i);
    m_beat = 0; m_ovf = 0; m_blk_cnt = 0; m_drop_cnt = 0;
    i_rst = 1; i_valid = 0; i_mx_vec = '0; i_mx_exp = '0; i_ready = 0;
    #1;
    test_reset();
    test_single();
    test_backpressure();
    test_back_to_back();
    test_overflow();
    test_full_last();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
